data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `data_mem` block between two requesters: master 0 is the core load/store unit, and master 1 is a secondary port such as the boot/debug loader or a DMA engine. It sits between the requesters and `data_mem`. It serialises accesses with round-robin priority and issues each access as a one-cycle `memread`/`memwrite` strobe. It tracks `data_mem`'s `clk_stall` busy signal to detect completion and returns read data to the winning master with a `done` pulse. A timeout guards against a hung memory.

---
 rtl/data_mem_arb_pkg.sv | 36 +++
 rtl/data_mem_arbiter_rr_arb2.sv | 35 +++
 rtl/data_mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg
//   Shared definitions for the data_mem arbiter: FSM state encoding,
//   master identifiers, the sign/width codes understood by data_mem and
//   the default access timeout.
package data_mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ACK   = 3'd2,
    ST_BUSY  = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_e;

  // Master identifiers (also the index into the per-master arrays).
  localparam logic MASTER_LSU = 1'b0;  // core load/store unit
  localparam logic MASTER_AUX = 1'b1;  // boot/debug loader or DMA

  // sign_mask codes shared with data_mem: bits [2:0] select the width,
  // bit 3 requests sign extension on loads.
  localparam logic [3:0] SM_BYTE   = 4'b0001;
  localparam logic [3:0] SM_HALF   = 4'b0011;
  localparam logic [3:0] SM_WORD   = 4'b0111;
  localparam logic [3:0] SM_SIGNED = 4'b1000;
  localparam logic [3:0] SM_BYTE_S = SM_BYTE | SM_SIGNED;
  localparam logic [3:0] SM_HALF_S = SM_HALF | SM_SIGNED;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int TMO_CNT_W       = 7;

  // One-hot mask bit for a master id.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin pick.
//   Ports:
//     req        in  2 : raw requests, bit N = master N
//     mask       in  2 : requests to ignore this cycle
//     last_grant in  1 : master served most recently
//     gnt_valid  out 1 : some unmasked request is present
//     gnt_id     out 1 : winning master
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic [1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    gnt_valid = |elig;
    gnt_id    = MASTER_LSU;
    case (elig)
      2'b01:   gnt_id = MASTER_LSU;
      2'b10:   gnt_id = MASTER_AUX;
      // Tie: the master that was not served last goes next.
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = MASTER_LSU;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-ported data_mem between the core LSU (master 0) and a
//   secondary port (master 1). Accesses are serialised round-robin, issued as
//   one-cycle memread/memwrite strobes, and completed when data_mem's
//   clk_stall busy flag has risen and fallen again. A timeout aborts an
//   access if the memory hangs.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     mN_req/addr/wdata/we/sign_mask : master N request (req held until done)
//     mN_rdata/done/err          : master N response (done is a 1-cycle pulse)
//     mem_addr/write_data/sign_mask  : registered copy of the granted request
//     mem_memread/memwrite       : one-cycle access strobes
//     mem_read_data, mem_clk_stall   : memory result and busy flag
//     timeout_seen               : sticky, set on any timeout
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [3:0]  m0_sign_mask,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [3:0]  m1_sign_mask,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        timeout_seen
);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT);

  // Per-master request views, indexed by master id.
  logic [1:0]  req_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        we_v    [2];
  logic [3:0]  sm_v    [2];

  assign req_v      = {m1_req, m0_req};
  assign addr_v[0]  = m0_addr;
  assign addr_v[1]  = m1_addr;
  assign wdata_v[0] = m0_wdata;
  assign wdata_v[1] = m1_wdata;
  assign we_v[0]    = m0_we;
  assign we_v[1]    = m1_we;
  assign sm_v[0]    = m0_sign_mask;
  assign sm_v[1]    = m1_sign_mask;

  arb_state_e           state_q, state_d;
  logic                 grant_id_q, grant_id_d;
  logic                 last_grant_q, last_grant_d;
  logic [1:0]           mask_q, mask_d;
  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;
  logic                 timeout_seen_q, timeout_seen_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           sm_q, sm_d;
  logic                 we_q, we_d;
  logic                 memread_q, memread_d;
  logic                 memwrite_q, memwrite_d;

  // Response to be presented in the next cycle (the RESP cycle).
  logic                 resp_fire_d;
  logic                 resp_err_d;
  logic [31:0]          resp_data_d;

  logic                 gnt_valid;
  logic                 gnt_id;

  rr_arb2 u_rr_arb2 (
    .req        (req_v),
    .mask       (mask_q),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    mask_d         = 2'b00;          // mask lives for exactly one IDLE cycle
    tmo_cnt_d      = tmo_cnt_q;
    timeout_seen_d = timeout_seen_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    sm_d           = sm_q;
    we_d           = we_q;
    memread_d      = 1'b0;           // strobes default low: never held
    memwrite_d     = 1'b0;
    resp_fire_d    = 1'b0;
    resp_err_d     = 1'b0;
    resp_data_d    = '0;
    tmo_cnt_inc    = tmo_cnt_q + TMO_CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        // A memory still draining an access (e.g. across our reset) blocks
        // any new issue, since data_mem would re-trigger on our strobe.
        if (!mem_clk_stall && gnt_valid) begin
          grant_id_d = gnt_id;
          addr_d     = addr_v[gnt_id];
          wdata_d    = wdata_v[gnt_id];
          sm_d       = sm_v[gnt_id];
          we_d       = we_v[gnt_id];
          memread_d  = ~we_v[gnt_id];
          memwrite_d = we_v[gnt_id];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        tmo_cnt_d = tmo_cnt_inc;
        if (tmo_cnt_inc == TMO_LIMIT) begin
          resp_fire_d    = 1'b1;
          resp_err_d     = 1'b1;
          timeout_seen_d = 1'b1;
          state_d        = ST_RESP;
        end else if (mem_clk_stall) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        tmo_cnt_d = tmo_cnt_inc;
        // A genuine completion wins over a timeout landing in the same cycle.
        if (!mem_clk_stall) begin
          resp_fire_d = 1'b1;
          resp_data_d = we_q ? 32'd0 : mem_read_data;
          state_d     = ST_RESP;
        end else if (tmo_cnt_inc == TMO_LIMIT) begin
          resp_fire_d    = 1'b1;
          resp_err_d     = 1'b1;
          timeout_seen_d = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        last_grant_d = grant_id_q;
        mask_d       = id_onehot(grant_id_q);
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_id_q     <= MASTER_LSU;
      last_grant_q   <= MASTER_AUX;  // so master 0 wins the first tie
      mask_q         <= 2'b00;
      tmo_cnt_q      <= '0;
      timeout_seen_q <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      sm_q           <= '0;
      we_q           <= 1'b0;
      memread_q      <= 1'b0;
      memwrite_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      mask_q         <= mask_d;
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_seen_q <= timeout_seen_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      sm_q           <= sm_d;
      we_q           <= we_d;
      memread_q      <= memread_d;
      memwrite_q     <= memwrite_d;
    end
  end

  // Per-master response registers; only the granted master sees the pulse,
  // and rdata is zero whenever done is low.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        hit;

    assign hit = resp_fire_d && (grant_id_q == 1'(gi));

    always_ff @(posedge clk) begin
      if (reset) begin
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        done_q  <= hit;
        err_q   <= hit && resp_err_d;
        rdata_q <= hit ? resp_data_d : 32'd0;
      end
    end
  end

  assign m0_done        = g_resp[0].done_q;
  assign m0_err         = g_resp[0].err_q;
  assign m0_rdata       = g_resp[0].rdata_q;
  assign m1_done        = g_resp[1].done_q;
  assign m1_err         = g_resp[1].err_q;
  assign m1_rdata       = g_resp[1].rdata_q;

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = sm_q;
  assign mem_memread    = memread_q;
  assign mem_memwrite   = memwrite_q;
  assign timeout_seen   = timeout_seen_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed bench for data_mem_arbiter with a behavioural data_mem model:
//   a strobe seen while idle raises clk_stall on the next cycle for
//   stall_len cycles; read data is whatever the bench drives.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [3:0]  m0_sign_mask, m1_sign_mask;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite, mem_clk_stall;
  logic        timeout_seen;

  int vectors = 0;
  int miscompares = 0;

  // data_mem model (no reset, like the real block)
  logic [15:0] mdl_cnt = 16'd0;
  int          stall_len = 2;
  logic        flush = 1'b0;

  always @(posedge clk) begin
    if (flush)                             mdl_cnt <= 16'd0;
    else if (mdl_cnt != 16'd0)             mdl_cnt <= mdl_cnt - 16'd1;
    else if (mem_memread || mem_memwrite)  mdl_cnt <= 16'(stall_len);
  end
  assign mem_clk_stall = (mdl_cnt != 16'd0);

  data_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_req         (m0_req),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_we          (m0_we),
    .m0_sign_mask   (m0_sign_mask),
    .m0_rdata       (m0_rdata),
    .m0_done        (m0_done),
    .m0_err         (m0_err),
    .m1_req         (m1_req),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_we          (m1_we),
    .m1_sign_mask   (m1_sign_mask),
    .m1_rdata       (m1_rdata),
    .m1_done        (m1_done),
    .m1_err         (m1_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_sign_mask  (mem_sign_mask),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall),
    .timeout_seen   (timeout_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_sign_mask = 0; m1_sign_mask = 0; mem_read_data = 0;
    tick();
    tick();
    vectors++;
    if ({mem_memread, mem_memwrite} !== 2'b00) begin
      miscompares++; $display("FAIL reset strobes: got %b expected 00", {mem_memread, mem_memwrite});
    end
    vectors++;
    if ({mem_addr, mem_write_data, mem_sign_mask} !== 68'd0) begin
      miscompares++; $display("FAIL reset mem regs: got %h/%h/%h expected 0", mem_addr, mem_write_data, mem_sign_mask);
    end
    vectors++;
    if ({m0_done, m1_done, m0_err, m1_err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset done/err: got %b expected 0000", {m0_done, m1_done, m0_err, m1_err});
    end
    vectors++;
    if ({m0_rdata, m1_rdata} !== 64'd0) begin
      miscompares++; $display("FAIL reset rdata: got %h/%h expected 0", m0_rdata, m1_rdata);
    end
    vectors++;
    if (timeout_seen !== 1'b0) begin
      miscompares++; $display("FAIL reset timeout_seen: got %b expected 0", timeout_seen);
    end
    reset = 1'b0;
    tick();
    $display("reset: checked reset state");
  endtask

  // Both masters request together straight after reset: m0 first.
  task automatic test_tie();
    m0_addr = 32'h100; m0_we = 0; m0_sign_mask = SM_WORD;
    m1_addr = 32'h200; m1_we = 0; m1_sign_mask = SM_WORD;
    mem_read_data = 32'h1111_1111;
    m0_req = 1; m1_req = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (m0_done !== (i == 5)) begin
        miscompares++; $display("FAIL tie m0_done c%0d: got %b expected %b", i, m0_done, (i == 5));
      end
      vectors++;
      if (m1_done !== (i == 11)) begin
        miscompares++; $display("FAIL tie m1_done c%0d: got %b expected %b", i, m1_done, (i == 11));
      end
      if (i == 1) begin
        vectors++;
        if (mem_addr !== 32'h100) begin
          miscompares++; $display("FAIL tie first addr: got %h expected 00000100", mem_addr);
        end
      end
      if (i == 7) begin
        vectors++;
        if (mem_memread !== 1'b1 || mem_addr !== 32'h200) begin
          miscompares++; $display("FAIL tie second issue: got rd=%b addr=%h expected rd=1 addr=00000200", mem_memread, mem_addr);
        end
      end
      if (i == 5) begin
        vectors++;
        if (m0_rdata !== 32'h1111_1111 || m1_rdata !== 32'd0) begin
          miscompares++; $display("FAIL tie m0_rdata: got %h (m1 %h) expected 11111111 (m1 0)", m0_rdata, m1_rdata);
        end
        m0_req = 0;
        mem_read_data = 32'h2222_2222;
      end
      if (i == 11) begin
        vectors++;
        if (m1_rdata !== 32'h2222_2222) begin
          miscompares++; $display("FAIL tie m1_rdata: got %h expected 22222222", m1_rdata);
        end
        m1_req = 0;
      end
    end
    tick();
    tick();
    $display("tie: m0 then m1 served");
  endtask

  // Both masters hold req for six accesses: grants must alternate 0,1,0,...
  task automatic test_continuous();
    int n_rd;
    n_rd = 0;
    m0_addr = 32'h300; m0_we = 0;
    m1_addr = 32'h304; m1_we = 0;
    mem_read_data = 32'hC0DE_0000;
    m0_req = 1; m1_req = 1;
    for (int i = 1; i <= 36; i++) begin
      logic        exp0, exp1;
      logic [31:0] exp_rd;
      tick();
      exp0   = (i % 6 == 5) && ((i / 6) % 2 == 0);
      exp1   = (i % 6 == 5) && ((i / 6) % 2 == 1);
      exp_rd = 32'hC0DE_0000 | 32'(i - 1);
      if (mem_memread) n_rd++;
      vectors++;
      if (m0_done !== exp0 || m1_done !== exp1) begin
        miscompares++; $display("FAIL cont done c%0d: got m0=%b m1=%b expected m0=%b m1=%b", i, m0_done, m1_done, exp0, exp1);
      end
      if (exp0) begin
        vectors++;
        if (m0_rdata !== exp_rd) begin
          miscompares++; $display("FAIL cont m0_rdata c%0d: got %h expected %h", i, m0_rdata, exp_rd);
        end
      end
      if (exp1) begin
        vectors++;
        if (m1_rdata !== exp_rd) begin
          miscompares++; $display("FAIL cont m1_rdata c%0d: got %h expected %h", i, m1_rdata, exp_rd);
        end
      end
      mem_read_data = 32'hC0DE_0000 | 32'(i);
      if (i == 35) begin
        m0_req = 0; m1_req = 0;
      end
    end
    vectors++;
    if (n_rd != 6) begin
      miscompares++; $display("FAIL cont read strobes: got %0d expected 6", n_rd);
    end
    tick();
    tick();
    $display("continuous: six alternating accesses");
  endtask

  task automatic test_single_load();
    m0_addr = 32'h4008; m0_we = 0; m0_sign_mask = SM_HALF_S;
    mem_read_data = 32'hDEAD_BEEF;
    m0_req = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vectors++;
      if (mem_memread !== (i == 1) || mem_memwrite !== 1'b0) begin
        miscompares++; $display("FAIL load strobe c%0d: got rd=%b wr=%b expected rd=%b wr=0", i, mem_memread, mem_memwrite, (i == 1));
      end
      vectors++;
      if (m0_done !== (i == 5)) begin
        miscompares++; $display("FAIL load m0_done c%0d: got %b expected %b", i, m0_done, (i == 5));
      end
      if (i == 1) begin
        vectors++;
        if (mem_addr !== 32'h4008 || mem_sign_mask !== SM_HALF_S) begin
          miscompares++; $display("FAIL load addr/mask: got %h/%b expected 00004008/%b", mem_addr, mem_sign_mask, SM_HALF_S);
        end
      end
      if (i == 5) begin
        vectors++;
        if (m0_rdata !== 32'hDEAD_BEEF || m0_err !== 1'b0) begin
          miscompares++; $display("FAIL load result: got %h err=%b expected deadbeef err=0", m0_rdata, m0_err);
        end
        m0_req = 0;
      end
    end
    tick();
    tick();
    $display("single_load: m0 load 0x4008 completed");
  endtask

  task automatic test_store();
    m1_addr = 32'h80; m1_wdata = 32'h0000_00A5; m1_we = 1; m1_sign_mask = SM_BYTE;
    mem_read_data = 32'hFFFF_FFFF;
    m1_req = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vectors++;
      if (mem_memwrite !== (i == 1) || mem_memread !== 1'b0) begin
        miscompares++; $display("FAIL store strobe c%0d: got wr=%b rd=%b expected wr=%b rd=0", i, mem_memwrite, mem_memread, (i == 1));
      end
      vectors++;
      if (m1_done !== (i == 5)) begin
        miscompares++; $display("FAIL store m1_done c%0d: got %b expected %b", i, m1_done, (i == 5));
      end
      if (i == 1) begin
        vectors++;
        if (mem_write_data !== 32'h0000_00A5 || mem_addr !== 32'h80 || mem_sign_mask !== SM_BYTE) begin
          miscompares++; $display("FAIL store regs: got %h/%h/%b expected 000000a5/00000080/%b", mem_write_data, mem_addr, mem_sign_mask, SM_BYTE);
        end
      end
      if (i == 5) begin
        vectors++;
        if (m1_rdata !== 32'd0 || m1_err !== 1'b0) begin
          miscompares++; $display("FAIL store result: got %h err=%b expected 0 err=0", m1_rdata, m1_err);
        end
        m1_req = 0;
      end
    end
    tick();
    tick();
    $display("store: m1 byte store completed");
  endtask

  // Memory stalls indefinitely: timeout after 8 ACK/BUSY cycles.
  task automatic test_hung();
    stall_len = 1000;
    m0_addr = 32'h500; m0_we = 0; m0_sign_mask = SM_WORD;
    mem_read_data = 32'h1234_5678;
    m0_req = 1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      vectors++;
      if (m0_done !== (i == 10)) begin
        miscompares++; $display("FAIL hung m0_done c%0d: got %b expected %b", i, m0_done, (i == 10));
      end
      vectors++;
      if (mem_memread !== (i == 1) || mem_memwrite !== 1'b0) begin
        miscompares++; $display("FAIL hung strobe c%0d: got rd=%b wr=%b expected rd=%b wr=0", i, mem_memread, mem_memwrite, (i == 1));
      end
      if (i == 10) begin
        vectors++;
        if (m0_err !== 1'b1 || m0_rdata !== 32'd0 || timeout_seen !== 1'b1) begin
          miscompares++; $display("FAIL hung result: got err=%b rdata=%h seen=%b expected err=1 rdata=0 seen=1", m0_err, m0_rdata, timeout_seen);
        end
        m0_req = 0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h600;  // must wait: memory still busy
      end
      if (i == 14) begin
        vectors++;
        if (timeout_seen !== 1'b1) begin
          miscompares++; $display("FAIL hung sticky: got %b expected 1", timeout_seen);
        end
        m1_req = 0;
        flush = 1'b1;
      end
    end
    tick();
    flush = 1'b0;
    stall_len = 2;
    tick();
    tick();
    $display("hung: timeout reported");
  endtask

  // Reset lands in BUSY while the memory stays busy two more cycles.
  task automatic test_reset_mid();
    stall_len = 4;
    m0_addr = 32'h400; m0_we = 0; m0_sign_mask = SM_WORD;
    mem_read_data = 32'h0F0F_0F0F;
    m0_req = 1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      vectors++;
      if (mem_memread !== (i == 1 || i == 7)) begin
        miscompares++; $display("FAIL rstmid memread c%0d: got %b expected %b", i, mem_memread, (i == 1 || i == 7));
      end
      vectors++;
      if (m0_done !== (i == 11)) begin
        miscompares++; $display("FAIL rstmid m0_done c%0d: got %b expected %b", i, m0_done, (i == 11));
      end
      if (i == 3) reset = 1'b1;
      if (i == 4) begin
        vectors++;
        if (mem_addr !== 32'd0 || timeout_seen !== 1'b0) begin
          miscompares++; $display("FAIL rstmid after reset: got addr=%h seen=%b expected addr=0 seen=0", mem_addr, timeout_seen);
        end
        reset = 1'b0;
        stall_len = 2;
      end
      if (i == 7) begin
        vectors++;
        if (mem_addr !== 32'h400) begin
          miscompares++; $display("FAIL rstmid reissue addr: got %h expected 00000400", mem_addr);
        end
      end
      if (i == 11) begin
        vectors++;
        if (m0_rdata !== 32'h0F0F_0F0F || m0_err !== 1'b0) begin
          miscompares++; $display("FAIL rstmid result: got %h err=%b expected 0f0f0f0f err=0", m0_rdata, m0_err);
        end
        m0_req = 0;
      end
    end
    tick();
    tick();
    $display("reset_mid: no done after reset, reissue after drain");
  endtask

  initial begin
    test_reset();
    test_tie();
    test_continuous();
    test_single_load();
    test_store();
    test_hung();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
